// File: rtl/gpio_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : gpio_result_reader
// Purpose  : Returns convolution results from the output BRAM (mem0) to the
//            MCU over the GPIO input bus. Each i_req toggle requests one word.
//            The word is acknowledged by toggling bit 31 of o_gpio_data.
//            Bit 30 (EOP) flags the last word of the image.
// Ports    : i_CLK        system clock
//            i_reset      asynchronous active-low reset
//            i_start      1-cycle pulse, arms a readout from address 0
//            i_imgLength  number of words N to return, sampled on i_start
//            i_req        MCU request toggle (asynchronous to i_CLK)
//            o_readAdd    BRAM read address
//            i_mem_data   BRAM registered data (valid 1 cycle after address)
//            o_gpio_data  {ACK, EOP, CHK, zero, data[RAM_WIDTH-1:0]}
//            o_busy       readout in progress
//            o_done       readout finished, until next i_start or reset
// Option   : GPIO_READBACK_CHECKSUM_EN -- the first request in DONE returns a
//            16-bit modulo sum of all returned words, with CHK=1.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_result_reader #(
  parameter int GPIO_D     = 32,
  parameter int RAM_WIDTH  = 13,
  parameter int NB_ADDRESS = 10,
  parameter int NB_IMAGE   = 10
) (
  input  logic                  i_CLK,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [NB_IMAGE-1:0]   i_imgLength,
  input  logic                  i_req,
  output logic [NB_ADDRESS-1:0] o_readAdd,
  input  logic [RAM_WIDTH-1:0]  i_mem_data,
  output logic [GPIO_D-1:0]     o_gpio_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int c_ACK_BIT = 31;
  localparam int c_EOP_BIT = 30;
  localparam int c_CHK_BIT = 29;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_REQ = 3'd1,
    READ     = 3'd2,
    CAPTURE  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;

  logic                    r_sync1;
  logic                    r_sync2;
  logic                    r_hist;
  logic                    r_reqEvt;
  logic                    r_pending;
  logic [1:0]              r_doneDly;
  logic [NB_ADDRESS-1:0]   r_count;
  logic [NB_ADDRESS-1:0]   r_lastAdd;
  logic [NB_ADDRESS-1:0]   r_readAdd;
  logic [GPIO_D-1:0]       r_gpioData;
`ifdef GPIO_READBACK_CHECKSUM_EN
  logic [15:0]             r_chkSum;
  logic                    r_chkSent;
`endif

  logic [NB_ADDRESS-1:0]   w_imgTrunc;
  logic                    w_reqHit;
  logic                    w_lastWord;
  logic [GPIO_D-1:0]       w_capWord;
  logic [GPIO_D-1:0]       w_doneWord;

  assign w_imgTrunc = NB_ADDRESS'(i_imgLength);
  assign w_reqHit   = r_reqEvt | r_pending;
  assign w_lastWord = (r_count == r_lastAdd);

  // Two-flop synchronizer plus history flop. The event is registered, so the
  // FSM reacts two edges after sync2 first shows the new level; together
  // with READ and CAPTURE this gives the fixed 5-edge request-to-ACK latency.
  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_hist   <= 1'b0;
      r_reqEvt <= 1'b0;
    end else begin
      r_sync1  <= i_req;
      r_sync2  <= r_sync1;
      r_hist   <= r_sync2;
      r_reqEvt <= r_sync2 ^ r_hist;
    end
  end

  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (i_start) begin
      w_nextState = (w_imgTrunc == '0) ? DONE : WAIT_REQ;
    end else begin
      case (r_state)
        IDLE:     w_nextState = IDLE;
        WAIT_REQ: if (w_reqHit) w_nextState = READ;
        READ:     w_nextState = CAPTURE;
        CAPTURE:  w_nextState = w_lastWord ? DONE : WAIT_REQ;
        DONE:     w_nextState = DONE;
        default:  w_nextState = IDLE;
      endcase
    end
  end

  // Words presented on the GPIO bus; ACK always flips relative to the
  // currently presented word so parity tracks served requests.
  always_comb begin
    w_capWord                   = '0;
    w_capWord[RAM_WIDTH-1:0]    = i_mem_data;
    w_capWord[c_EOP_BIT]        = w_lastWord;
    w_capWord[c_ACK_BIT]        = ~r_gpioData[c_ACK_BIT];

    w_doneWord                  = '0;
    w_doneWord[c_EOP_BIT]       = 1'b1;
    w_doneWord[c_ACK_BIT]       = ~r_gpioData[c_ACK_BIT];
`ifdef GPIO_READBACK_CHECKSUM_EN
    if (!r_chkSent) begin
      w_doneWord[15:0]          = r_chkSum;
      w_doneWord[c_CHK_BIT]     = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      r_count    <= '0;
      r_lastAdd  <= '0;
      r_readAdd  <= '0;
      r_gpioData <= '0;
      r_pending  <= 1'b0;
      r_doneDly  <= '0;
`ifdef GPIO_READBACK_CHECKSUM_EN
      r_chkSum   <= '0;
      r_chkSent  <= 1'b0;
`endif
    end else if (i_start) begin
      // Restart from any state; the presented word (and its ACK parity) is
      // left untouched so the MCU's toggle bookkeeping stays valid.
      r_count    <= '0;
      r_lastAdd  <= w_imgTrunc - NB_ADDRESS'(1);
      r_readAdd  <= '0;
      r_pending  <= 1'b0;
      r_doneDly  <= '0;
`ifdef GPIO_READBACK_CHECKSUM_EN
      r_chkSum   <= '0;
      r_chkSent  <= 1'b0;
`endif
    end else begin
      case (r_state)
        WAIT_REQ: begin
          // Address is driven for the whole READ cycle so the BRAM has
          // registered the word by the time CAPTURE samples it.
          if (w_reqHit) begin
            r_readAdd <= r_count;
            r_pending <= 1'b0;
          end
        end
        READ: begin
          if (r_reqEvt) r_pending <= 1'b1;
        end
        CAPTURE: begin
          if (r_reqEvt) r_pending <= 1'b1;
          r_gpioData <= w_capWord;
`ifdef GPIO_READBACK_CHECKSUM_EN
          r_chkSum   <= r_chkSum + 16'(i_mem_data);
`endif
          if (!w_lastWord) r_count <= r_count + NB_ADDRESS'(1);
        end
        DONE: begin
          // Delay line aligns DONE answers with the normal data latency.
          r_pending <= 1'b0;
          r_doneDly <= {r_doneDly[0], w_reqHit};
          if (r_doneDly[1]) begin
            r_gpioData <= w_doneWord;
`ifdef GPIO_READBACK_CHECKSUM_EN
            r_chkSent  <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign o_readAdd   = r_readAdd;
  assign o_gpio_data = r_gpioData;
  assign o_busy      = (r_state == WAIT_REQ) || (r_state == READ) || (r_state == CAPTURE);
  assign o_done      = (r_state == DONE);

endmodule
`default_nettype wire

// File: doc/gpio_result_reader.md
Name: gpio_result_reader

Overview:
- Return path from fabric to MCU: streams convolution results from the output BRAM (mem0) back over the GPIO input bus, one word per MCU request.
- Replaces the direct mem0-to-GPIO wiring with a toggle handshake, an address counter and end-of-image signalling.
- Sits between the mem0 read port (read address, registered data out) and gpio_i_data_tri_i. Runs after the FSM reports end of processing.

Parameters:
- GPIO_D, 32, GPIO bus width; must be 32.
- RAM_WIDTH, 13, BRAM word width (signed conv result).
- NB_ADDRESS, 10, BRAM address width.
- NB_IMAGE, 10, width of the word-count input.

Ports:
- i_CLK  in  1  system clock.
- i_reset  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle pulse: arm a readout from address 0.
- i_imgLength  in  NB_IMAGE  number of words N to return; sampled on i_start.
- i_req  in  1  MCU request toggle (GPIO out bit 28); each transition requests one word.
- o_readAdd  out  NB_ADDRESS  BRAM read address.
- i_mem_data  in  RAM_WIDTH  BRAM data out; valid 1 cycle after o_readAdd.
- o_gpio_data  out  GPIO_D  to gpio_i_data_tri_i. Bit layout:
  - [RAM_WIDTH-1:0] data
  - [28:RAM_WIDTH] zero
  - [29] CHK
  - [30] EOP
  - [31] ACK
- o_busy  out  1  high from accepted i_start until DONE.
- o_done  out  1  high in DONE, until next i_start or reset.

Behaviour:
- Reset (i_reset=0, asynchronous): o_readAdd=0, o_gpio_data=0, o_busy=0, o_done=0, state IDLE, synchronizer flops=0, word counter=0.
- i_req passes a 2-flop synchronizer plus one history flop. A request event is sync2 XOR history.
- ACK = toggle parity of served requests. The MCU polls until bit31 equals its request bit.
- States:
  - IDLE: waits for i_start. Events are consumed and ignored; ACK does not change.
  - On i_start: latch N, counter=0, o_readAdd=0. Go to DONE if N=0, else WAIT_REQ.
  - WAIT_REQ: on request event go to READ.
  - READ: o_readAdd=counter. One cycle, then go to CAPTURE.
  - CAPTURE: register i_mem_data bit-exact into [RAM_WIDTH-1:0]. Set EOP=1 if counter=N-1. Toggle ACK. Data, EOP and ACK change on the same edge.
    - Then: if counter=N-1, go to DONE. Else counter+1 and go to WAIT_REQ.
  - DONE: o_done=1, o_busy=0. Each request event is answered 3 cycles after detection with data=0, EOP=1 and toggled ACK, so the MCU never deadlocks.
- Latency: ACK toggles exactly 5 i_CLK rising edges after the edge that first samples the new i_req level.
- o_gpio_data holds its value between acknowledgements.
- Request events arriving during READ or CAPTURE are held pending (at most one) and served next. Further events before service are lost; the MCU protocol forbids them.
- i_start in any state aborts and restarts: counter=0, pending request cleared, ACK kept (parity stays consistent with the MCU).
- Counter arithmetic: N is truncated to NB_ADDRESS bits. N > 2^NB_ADDRESS is not supported. The address never wraps within a readout.

Optional Feature:
- Macro: GPIO_READBACK_CHECKSUM_EN.
- Enabled:
  - A 16-bit modulo sum of the zero-extended returned data words is accumulated; it is cleared on i_start.
  - The first request in DONE returns the checksum in [15:0] with CHK=1, EOP=1.
  - Later DONE requests return data=0, CHK=0, EOP=1.
- Disabled: bit29 is always 0 and there is no accumulator.

Test Plan:
- Reset, then bank mem0 with words 0..3 = 13'h0001, 13'h1FFF, 13'h0800, 13'h0123. Pulse i_start with N=4. Toggle i_req 4 times, waiting for ACK each time.
  -> Data returned in order. EOP=1 only on the 4th word. ACK 5 cycles after each toggle. o_done=1 after the 4th word.
- i_start with N=0 -> o_done=1 next cycle. One toggle -> data=0, EOP=1, ACK toggles.
- N=3: toggle twice, then pulse i_start (N=2) -> counter restarts. Next toggle returns word 0 with EOP=0. ACK parity continues.
- Assert i_reset=0 asynchronously during READ -> all outputs 0 immediately, without waiting for a clock edge. Post-reset toggles in IDLE produce no ACK.
- Two i_req toggles 1 cycle apart in WAIT_REQ -> second is held pending and served. Two ACK toggles occur, the second 3 cycles after the first.
- With GPIO_READBACK_CHECKSUM_EN, N=4 with the data above, then one extra toggle -> [15:0]=16'h2923, CHK=1, EOP=1.
